// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB-first, one full adder with a
// registered carry, one operand bit per clock.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, sub, a, b  - request, add(0)/subtract(1), operands (sampled in IDLE)
//   busy              - high while operand bits are being processed
//   done              - one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf    - result, carry/no-borrow, signed overflow (held)
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    // Upper WIDTH-1 result bits; the final bit goes straight into sum.
    logic [WIDTH-2:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_nxt;

    // Single full adder on the current LSBs.
    always_comb begin
        sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
        carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    // Subtract as a + ~b + 1: the +1 enters as the initial carry.
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d  = 1'b1;
                carry_d = carry_nxt;
                res_d   = (WIDTH-1)'({sum_bit, res_q} >> 1);
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {sum_bit, res_q};
                    cout_d  = carry_nxt;
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ carry_nxt;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks of serial_addsub at WIDTH=8 and WIDTH=4.
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;

    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4, sub4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int ncmp = 0;
    int nerr = 0;
    int lat;
    int bcy;
    int ndone;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: raise start for the next posedge (edge 0),
    // return at the following negedge (busy cycle 1) with start low.
    task automatic launch(input bit w4, input bit s, input logic [7:0] x, input logic [7:0] y);
        if (w4) begin
            start4 = 1'b1; sub4 = s; a4 = x[3:0]; b4 = y[3:0];
        end else begin
            start8 = 1'b1; sub8 = s; a8 = x; b8 = y;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    // Count cycles (1 = first cycle after edge 0) until done, bounded.
    task automatic wait_done(input bit w4, output int n, output int nb);
        n  = 1;
        nb = 0;
        for (int k = 0; k < 60; k++) begin
            if (w4 ? busy4 : busy8) nb++;
            if (w4 ? done4 : done8) break;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_done", 32'(done8), 32'h0);
        check("rst_sum",  32'(sum8),  32'h0);
        check("rst_cout_ovf", 32'({cout8, ovf8}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 0x3C + 0x05
        launch(1'b0, 1'b0, 8'h3C, 8'h05);
        wait_done(1'b0, lat, bcy);
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_busy_cycles", 32'(bcy), 32'd8);
        check("t1_sum", 32'(sum8), 32'h41);
        check("t1_cout_ovf", 32'({cout8, ovf8}), 32'h0);
        @(negedge clk);
        check("t1_done_width", 32'(done8), 32'h0);

        // 2: carry out, then signed overflow
        launch(1'b0, 1'b0, 8'hFF, 8'h01);
        wait_done(1'b0, lat, bcy);
        check("t2a_sum", 32'(sum8), 32'h00);
        check("t2a_cout_ovf", 32'({cout8, ovf8}), 32'h2);
        @(negedge clk);
        launch(1'b0, 1'b0, 8'h7F, 8'h01);
        wait_done(1'b0, lat, bcy);
        check("t2b_sum", 32'(sum8), 32'h80);
        check("t2b_cout_ovf", 32'({cout8, ovf8}), 32'h1);
        @(negedge clk);

        // 3: subtract with borrow, then with overflow
        launch(1'b0, 1'b1, 8'h05, 8'h07);
        wait_done(1'b0, lat, bcy);
        check("t3a_sum", 32'(sum8), 32'hFE);
        check("t3a_cout_ovf", 32'({cout8, ovf8}), 32'h0);
        @(negedge clk);
        launch(1'b0, 1'b1, 8'h80, 8'h01);
        wait_done(1'b0, lat, bcy);
        check("t3b_sum", 32'(sum8), 32'h7F);
        check("t3b_cout_ovf", 32'({cout8, ovf8}), 32'h3);
        @(negedge clk);

        // 4: starts during RUN and DONE ignored, next-cycle start accepted
        launch(1'b0, 1'b0, 8'h10, 8'h20);
        ndone = 0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 4; c < 9; c++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        check("t4_done_early", 32'(ndone), 32'd0);
        check("t4_done", 32'(done8), 32'h1);
        check("t4_sum", 32'(sum8), 32'h30);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        check("t4_done_once", 32'(done8), 32'h0);
        check("t4_done_start_ignored", 32'(busy8), 32'h0);
        launch(1'b0, 1'b0, 8'h11, 8'h22);
        wait_done(1'b0, lat, bcy);
        check("t4_b2b_latency", 32'(lat), 32'd9);
        check("t4_b2b_sum", 32'(sum8), 32'h33);
        @(negedge clk);

        // 5: asynchronous reset mid-operation
        launch(1'b0, 1'b0, 8'hF0, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy8), 32'h0);
        check("t5_done", 32'(done8), 32'h0);
        check("t5_sum", 32'(sum8), 32'h0);
        check("t5_cout_ovf", 32'({cout8, ovf8}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8 || busy8) ndone++;
            @(negedge clk);
        end
        check("t5_no_done", 32'(ndone), 32'd0);
        launch(1'b0, 1'b0, 8'h01, 8'h01);
        wait_done(1'b0, lat, bcy);
        check("t5_latency", 32'(lat), 32'd9);
        check("t5_sum", 32'(sum8), 32'h02);
        @(negedge clk);

        // 6: WIDTH=4
        launch(1'b1, 1'b0, 8'h0F, 8'h01);
        wait_done(1'b1, lat, bcy);
        check("t6a_latency", 32'(lat), 32'd5);
        check("t6a_busy_cycles", 32'(bcy), 32'd4);
        check("t6a_sum", 32'(sum4), 32'h0);
        check("t6a_cout_ovf", 32'({cout4, ovf4}), 32'h2);
        @(negedge clk);
        launch(1'b1, 1'b1, 8'h08, 8'h01);
        wait_done(1'b1, lat, bcy);
        check("t6b_sum", 32'(sum4), 32'h7);
        check("t6b_cout_ovf", 32'({cout4, ovf4}), 32'h3);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor, the multi-bit successor to the team's single-bit half adder. It accepts two WIDTH-bit operands on a start pulse and processes them LSB-first, one bit per clock, through a single full adder with a registered carry. It reports the sum, carry/no-borrow and signed overflow. It sits behind the top-level IO wrapper: operands come from the dedicated inputs and results go to the dedicated outputs.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset; asynchronous, active-low.
start  input  1  request operation; sampled only in IDLE.
sub  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse; result registers updated in this cycle.
sum  output  WIDTH  result, held until the next done.
cout  output  1  final carry out; for subtract, 1 = no borrow (a >= b unsigned).
ovf  output  1  signed two's-complement overflow of the result.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, cout and ovf = 0; sum = 0; the internal shift registers, carry and counter are cleared. Reset asserted mid-operation aborts the operation with no done pulse.
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - busy = 0 and done = 0.
  - If start = 1 at the clock edge:
    - load opA = a;
    - load opB = b when sub = 0, or ~b when sub = 1;
    - set carry = sub and counter = 0;
    - go to RUN.
- RUN (busy = 1), on each edge:
  - s = opA[0] ^ opB[0] ^ carry, and carry <= majority(opA[0], opB[0], carry);
  - s shifts into the MSB of the result shift register; opA and opB shift right by 1; counter increments.
  - On the edge with counter == WIDTH-1:
    - record carry-into-MSB (the carry before that edge);
    - copy the result shift register (including that bit) into sum;
    - cout <= new carry, ovf <= carry-into-MSB ^ new carry;
    - go to DONE.
- DONE: done = 1 and busy = 0 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start is sampled at edge 0. busy is high for the WIDTH cycles after edge 0. done is high in the cycle after edge WIDTH, i.e. done rises WIDTH+1 cycles after start is sampled.
- Ignored starts:
  - start during RUN or DONE is ignored; no queueing takes place.
  - a, b and sub changing during RUN have no effect.
- Back-to-back operation: start high in the cycle after DONE (back in IDLE) is accepted. Maximum throughput is one result per WIDTH+1 cycles.
- Output stability: sum, cout and ovf change only at the edge that enters DONE and otherwise hold their last result. They never show partial values.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

Test Plan:
1. WIDTH=8, add 0x3C+0x05 -> sum=0x41, cout=0, ovf=0; done rises exactly 9 cycles after start is sampled and is high for 1 cycle; busy is high for 8 cycles.
2. WIDTH=8, add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Then add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
3. WIDTH=8, sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0. Then sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
4. WIDTH=8, start 0x10+0x20, then pulse start with a=0xAA, b=0x55 at busy cycle 3 and again in the DONE cycle -> single result sum=0x30, exactly one done pulse. A start in the following cycle is accepted (its done comes 9 cycles later).
5. rst_n low for 1 cycle at busy cycle 4 -> busy, done, sum, cout and ovf read 0 immediately, before the next edge. No done pulse follows. A new add of 0x01+0x01 then gives sum=0x02.
6. WIDTH=4, add 0xF+0x1 -> sum=0x0, cout=1, ovf=0, done 5 cycles after start. Then sub 0x8-0x1 -> sum=0x7, cout=1, ovf=1.
